// File: rtl/axi_channel_slice.sv
// axi_channel_slice: one AXI channel buffer (payload + LAST). DEPTH=0 is a pass-through,
// DEPTH>=1 a registered circular buffer with optional store-and-forward packet mode.
module axi_channel_slice #(
    parameter int WIDTH       = 1,
    parameter int DEPTH       = 2,
    parameter int PACKET_MODE = 0,
    localparam int CNT_W      = (DEPTH > 0) ? $clog2(DEPTH + 1) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] pkt_count
);

    if (DEPTH == 0) begin : g_wire
        logic unused_clk_rst;

        assign unused_clk_rst = clk ^ rst;
        assign out_data       = in_data;
        assign out_last       = in_last;
        assign out_valid      = in_valid;
        assign in_ready       = out_ready;
        assign count          = '0;
        assign pkt_count      = '0;
    end else begin : g_buf
        localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
        localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
        localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

        logic [WIDTH-1:0] mem_data [DEPTH];
        logic             mem_last [DEPTH];
        logic [PTR_W-1:0] rd_ptr;
        logic [PTR_W-1:0] wr_ptr;
        logic             full;
        logic             empty;
        logic             head_ok;
        logic             push;
        logic             pop;
        logic             push_last;
        logic             pop_last;

        assign full  = (count == FULL_CNT);
        assign empty = (count == '0);

        // in_ready depends only on registered state, which breaks the ready path.
        assign in_ready = ~full & ~rst;

        if (PACKET_MODE != 0) begin : g_pkt
            // A full buffer releases its head even without a LAST so long bursts cannot deadlock.
            assign head_ok = (pkt_count != '0) | full;
        end else begin : g_cut
            assign head_ok = 1'b1;
        end

        assign out_valid = ~empty & head_ok;
        assign out_data  = mem_data[rd_ptr];
        assign out_last  = mem_last[rd_ptr];

        assign push      = in_valid & in_ready;
        assign pop       = out_valid & out_ready;
        assign push_last = push & in_last;
        assign pop_last  = pop & out_last;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rd_ptr    <= '0;
                wr_ptr    <= '0;
                count     <= '0;
                pkt_count <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
                end
                if (push & ~pop) begin
                    count <= count + 1'b1;
                end else if (~push & pop) begin
                    count <= count - 1'b1;
                end
                if (push_last & ~pop_last) begin
                    pkt_count <= pkt_count + 1'b1;
                end else if (~push_last & pop_last) begin
                    pkt_count <= pkt_count - 1'b1;
                end
            end
        end

        // NOTE: storage is deliberately not reset; only pointers and counters are, and the
        // contents are don't-care whenever out_valid is low.
        always_ff @(posedge clk) begin
            if (push) begin
                mem_data[wr_ptr] <= in_data;
                mem_last[wr_ptr] <= in_last;
            end
        end

`ifndef SYNTHESIS
        a_no_push_full: assert property (@(posedge clk) disable iff (rst) !(push && full));
        a_no_pop_empty: assert property (@(posedge clk) disable iff (rst) !(pop && empty));
        a_pkt_le_count: assert property (@(posedge clk) disable iff (rst) pkt_count <= count);
        a_out_stable: assert property (@(posedge clk) disable iff (rst)
            (out_valid && !out_ready) |=> (out_valid && $stable(out_data) && $stable(out_last)));
`endif
    end

endmodule

// File: tb/tb_axi_channel_slice.sv
// Bench for axi_channel_slice: directed scenarios on several configurations plus a
// randomized run against a queue-based reference model.
module tb_axi_channel_slice;

    localparam int N = 5;
    // Instances: 0 = D2 cut-through, 1 = D4 packet, 2 = D2 packet, 3 = D1, 4 = D0 wires.
    localparam int DEP [N] = '{2, 4, 2, 1, 0};
    localparam int PKT [N] = '{0, 1, 1, 0, 0};

    typedef logic [8:0] beat_t;  // {last, data}

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data  [N];
    logic       in_last  [N];
    logic       in_valid [N];
    logic       in_ready [N];
    logic [7:0] out_data [N];
    logic       out_last [N];
    logic       out_valid[N];
    logic       out_ready[N];
    logic [2:0] cnt      [N];
    logic [2:0] pcnt     [N];

    logic [1:0] c0, p0, c2, p2;
    logic [2:0] c1, p1;
    logic       c3, p3, c4, p4;

    assign cnt[0] = 3'(c0);
    assign cnt[1] = c1;
    assign cnt[2] = 3'(c2);
    assign cnt[3] = 3'(c3);
    assign cnt[4] = 3'(c4);
    assign pcnt[0] = 3'(p0);
    assign pcnt[1] = p1;
    assign pcnt[2] = 3'(p2);
    assign pcnt[3] = 3'(p3);
    assign pcnt[4] = 3'(p4);

    int checks = 0;
    int errors = 0;

    beat_t mq [N][$];

    always #5 clk = ~clk;

    axi_channel_slice #(.WIDTH(8), .DEPTH(2), .PACKET_MODE(0)) u_d2 (
        .clk(clk), .rst(rst), .in_data(in_data[0]), .in_last(in_last[0]), .in_valid(in_valid[0]),
        .in_ready(in_ready[0]), .out_data(out_data[0]), .out_last(out_last[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .count(c0), .pkt_count(p0));
    axi_channel_slice #(.WIDTH(8), .DEPTH(4), .PACKET_MODE(1)) u_d4p (
        .clk(clk), .rst(rst), .in_data(in_data[1]), .in_last(in_last[1]), .in_valid(in_valid[1]),
        .in_ready(in_ready[1]), .out_data(out_data[1]), .out_last(out_last[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .count(c1), .pkt_count(p1));
    axi_channel_slice #(.WIDTH(8), .DEPTH(2), .PACKET_MODE(1)) u_d2p (
        .clk(clk), .rst(rst), .in_data(in_data[2]), .in_last(in_last[2]), .in_valid(in_valid[2]),
        .in_ready(in_ready[2]), .out_data(out_data[2]), .out_last(out_last[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]), .count(c2), .pkt_count(p2));
    axi_channel_slice #(.WIDTH(8), .DEPTH(1), .PACKET_MODE(0)) u_d1 (
        .clk(clk), .rst(rst), .in_data(in_data[3]), .in_last(in_last[3]), .in_valid(in_valid[3]),
        .in_ready(in_ready[3]), .out_data(out_data[3]), .out_last(out_last[3]),
        .out_valid(out_valid[3]), .out_ready(out_ready[3]), .count(c3), .pkt_count(p3));
    axi_channel_slice #(.WIDTH(8), .DEPTH(0), .PACKET_MODE(0)) u_d0 (
        .clk(clk), .rst(rst), .in_data(in_data[4]), .in_last(in_last[4]), .in_valid(in_valid[4]),
        .in_ready(in_ready[4]), .out_data(out_data[4]), .out_last(out_last[4]),
        .out_valid(out_valid[4]), .out_ready(out_ready[4]), .count(c4), .pkt_count(p4));

    task automatic idle_all();
        for (int k = 0; k < N; k++) begin
            in_data[k]   = '0;
            in_last[k]   = 1'b0;
            in_valid[k]  = 1'b0;
            out_ready[k] = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_all();
        @(negedge clk);
        #1;
        for (int k = 0; k < N; k++) begin
            checks++;
            if (in_ready[k] !== 1'b0) begin
                errors++; $display("FAIL reset_in_ready[%0d]: got %b expected 0", k, in_ready[k]);
            end
            checks++;
            if (out_valid[k] !== 1'b0) begin
                errors++; $display("FAIL reset_out_valid[%0d]: got %b expected 0", k, out_valid[k]);
            end
            checks++;
            if (cnt[k] !== 3'd0 || pcnt[k] !== 3'd0) begin
                errors++; $display("FAIL reset_counts[%0d]: got %0d/%0d expected 0/0", k, cnt[k], pcnt[k]);
            end
        end
        rst = 1'b0;
        #1;
        for (int k = 0; k < N - 1; k++) begin
            checks++;
            if (in_ready[k] !== 1'b1) begin
                errors++; $display("FAIL release_in_ready[%0d]: got %b expected 1", k, in_ready[k]);
            end
        end
        out_ready[4] = 1'b1;
        in_valid[4]  = 1'b1;
        in_data[4]   = 8'h3C;
        in_last[4]   = 1'b1;
        #1;
        checks++;
        if (in_ready[4] !== 1'b1 || out_valid[4] !== 1'b1 || out_data[4] !== 8'h3C || out_last[4] !== 1'b1) begin
            errors++;
            $display("FAIL d0_passthru: got rdy %b vld %b data %h last %b expected 1 1 3c 1",
                     in_ready[4], out_valid[4], out_data[4], out_last[4]);
        end
        idle_all();
    endtask

    task automatic test_stream();
        logic       exp_v;
        logic [2:0] exp_c;
        out_ready[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid[0] = (i < 8);
            in_data[0]  = 8'(i + 1);
            in_last[0]  = 1'b1;
            #1;
            exp_v = (i >= 1 && i <= 8);
            exp_c = exp_v ? 3'd1 : 3'd0;
            checks++;
            if (out_valid[0] !== exp_v) begin
                errors++; $display("FAIL stream_valid cyc %0d: got %b expected %b", i, out_valid[0], exp_v);
            end
            if (exp_v) begin
                checks++;
                if (out_data[0] !== 8'(i)) begin
                    errors++; $display("FAIL stream_data cyc %0d: got %h expected %h", i, out_data[0], 8'(i));
                end
            end
            checks++;
            if (in_ready[0] !== 1'b1) begin
                errors++; $display("FAIL stream_ready cyc %0d: got %b expected 1", i, in_ready[0]);
            end
            checks++;
            if (cnt[0] !== exp_c || pcnt[0] !== exp_c) begin
                errors++; $display("FAIL stream_count cyc %0d: got %0d/%0d expected %0d", i, cnt[0], pcnt[0], exp_c);
            end
        end
        idle_all();
    endtask

    task automatic test_full();
        @(negedge clk);
        in_valid[0] = 1'b1; in_data[0] = 8'h0A; in_last[0] = 1'b0;
        @(negedge clk);
        in_data[0] = 8'h0B; in_last[0] = 1'b1;
        @(negedge clk);
        in_valid[0] = 1'b0;
        #1;
        checks++;
        if (cnt[0] !== 3'd2 || pcnt[0] !== 3'd1 || in_ready[0] !== 1'b0) begin
            errors++; $display("FAIL full_state: got cnt %0d pkt %0d rdy %b expected 2 1 0", cnt[0], pcnt[0], in_ready[0]);
        end
        checks++;
        if (out_valid[0] !== 1'b1 || out_data[0] !== 8'h0A) begin
            errors++; $display("FAIL full_head: got vld %b data %h expected 1 0a", out_valid[0], out_data[0]);
        end
        out_ready[0] = 1'b1;
        #1;
        checks++;
        if (in_ready[0] !== 1'b0) begin
            errors++; $display("FAIL full_ready_same_cycle: got %b expected 0", in_ready[0]);
        end
        @(negedge clk);
        #1;
        checks++;
        if (out_valid[0] !== 1'b1 || out_data[0] !== 8'h0B || out_last[0] !== 1'b1) begin
            errors++; $display("FAIL full_second: got vld %b data %h last %b expected 1 0b 1", out_valid[0], out_data[0], out_last[0]);
        end
        checks++;
        if (in_ready[0] !== 1'b1 || cnt[0] !== 3'd1 || pcnt[0] !== 3'd1) begin
            errors++; $display("FAIL full_after_pop: got rdy %b cnt %0d pkt %0d expected 1 1 1", in_ready[0], cnt[0], pcnt[0]);
        end
        @(negedge clk);
        #1;
        checks++;
        if (out_valid[0] !== 1'b0 || cnt[0] !== 3'd0 || pcnt[0] !== 3'd0) begin
            errors++; $display("FAIL full_drained: got vld %b cnt %0d pkt %0d expected 0 0 0", out_valid[0], cnt[0], pcnt[0]);
        end
        idle_all();
    endtask

    task automatic test_packet();
        int ec [7] = '{0, 1, 2, 3, 2, 1, 0};
        int ep [7] = '{0, 0, 0, 1, 1, 1, 0};
        logic exp_v;
        out_ready[1] = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            in_valid[1] = (i < 3);
            in_data[1]  = 8'(8'h30 + i);
            in_last[1]  = (i == 2);
            #1;
            exp_v = (i >= 3 && i <= 5);
            checks++;
            if (out_valid[1] !== exp_v) begin
                errors++; $display("FAIL pkt_valid cyc %0d: got %b expected %b", i, out_valid[1], exp_v);
            end
            if (exp_v) begin
                checks++;
                if (out_data[1] !== 8'(8'h30 + i - 3) || out_last[1] !== (i == 5)) begin
                    errors++; $display("FAIL pkt_beat cyc %0d: got %h/%b expected %h/%b",
                                       i, out_data[1], out_last[1], 8'(8'h30 + i - 3), (i == 5));
                end
            end
            checks++;
            if (cnt[1] !== 3'(ec[i]) || pcnt[1] !== 3'(ep[i])) begin
                errors++; $display("FAIL pkt_count cyc %0d: got %0d/%0d expected %0d/%0d", i, cnt[1], pcnt[1], ec[i], ep[i]);
            end
        end
        idle_all();
    endtask

    task automatic test_long_burst();
        int sent = 0;
        int got  = 0;
        int cyc  = 0;
        bit saw_override = 1'b0;
        out_ready[2] = 1'b1;
        while (got < 5 && cyc < 60) begin
            @(negedge clk);
            in_valid[2] = (sent < 5);
            in_data[2]  = 8'(8'h21 + sent);
            in_last[2]  = (sent == 4);
            #1;
            if (out_valid[2] === 1'b1) begin
                checks++;
                if (out_data[2] !== 8'(8'h21 + got) || out_last[2] !== (got == 4)) begin
                    errors++; $display("FAIL burst_beat %0d: got %h/%b expected %h/%b",
                                       got, out_data[2], out_last[2], 8'(8'h21 + got), (got == 4));
                end
                if (pcnt[2] === 3'd0) saw_override = 1'b1;
                got++;
            end
            if (in_valid[2] && in_ready[2]) sent++;
            cyc++;
        end
        idle_all();
        checks++;
        if (got != 5) begin
            errors++; $display("FAIL burst_delivered: got %0d beats expected 5 within 60 cycles", got);
        end
        checks++;
        if (!saw_override) begin
            errors++; $display("FAIL burst_override: got no release before LAST expected full-release");
        end
    endtask

    task automatic test_half_rate();
        int sent = 0;
        int got  = 0;
        out_ready[3] = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            in_valid[3] = 1'b1;
            in_data[3]  = 8'(8'h40 + sent);
            in_last[3]  = 1'b1;
            #1;
            checks++;
            if (in_ready[3] !== (cyc % 2 == 0) || cnt[3] !== 3'(cyc % 2)) begin
                errors++; $display("FAIL half_ready cyc %0d: got rdy %b cnt %0d expected %b %0d",
                                   cyc, in_ready[3], cnt[3], (cyc % 2 == 0), cyc % 2);
            end
            checks++;
            if (out_valid[3] !== (cyc % 2 == 1)) begin
                errors++; $display("FAIL half_valid cyc %0d: got %b expected %b", cyc, out_valid[3], (cyc % 2 == 1));
            end
            if (out_valid[3] === 1'b1) begin
                checks++;
                if (out_data[3] !== 8'(8'h40 + got)) begin
                    errors++; $display("FAIL half_data %0d: got %h expected %h", got, out_data[3], 8'(8'h40 + got));
                end
                got++;
            end
            if (in_valid[3] && in_ready[3]) sent++;
        end
        idle_all();
        checks++;
        if (got != 10) begin
            errors++; $display("FAIL half_rate_total: got %0d beats expected 10 in 20 cycles", got);
        end
    endtask

    task automatic test_mid_reset();
        beat_t seq [3] = '{9'h161, 9'h062, 9'h063};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid[1] = 1'b1;
            {in_last[1], in_data[1]} = seq[i];
        end
        @(negedge clk);
        in_valid[1] = 1'b0;
        #1;
        checks++;
        if (cnt[1] !== 3'd3 || pcnt[1] !== 3'd1 || out_valid[1] !== 1'b1) begin
            errors++; $display("FAIL midrst_pre: got cnt %0d pkt %0d vld %b expected 3 1 1", cnt[1], pcnt[1], out_valid[1]);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid[1] !== 1'b0 || cnt[1] !== 3'd0 || pcnt[1] !== 3'd0 || in_ready[1] !== 1'b0) begin
            errors++; $display("FAIL midrst_async: got vld %b cnt %0d pkt %0d rdy %b expected 0 0 0 0",
                               out_valid[1], cnt[1], pcnt[1], in_ready[1]);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready[1] !== 1'b1 || out_valid[1] !== 1'b0) begin
            errors++; $display("FAIL midrst_release: got rdy %b vld %b expected 1 0", in_ready[1], out_valid[1]);
        end
        in_valid[1] = 1'b1; in_data[1] = 8'h55; in_last[1] = 1'b1; out_ready[1] = 1'b1;
        @(negedge clk);
        in_valid[1] = 1'b0;
        #1;
        checks++;
        if (out_valid[1] !== 1'b1 || out_data[1] !== 8'h55 || cnt[1] !== 3'd1) begin
            errors++; $display("FAIL midrst_first: got vld %b data %h cnt %0d expected 1 55 1", out_valid[1], out_data[1], cnt[1]);
        end
        @(negedge clk);
        #1;
        checks++;
        if (out_valid[1] !== 1'b0 || cnt[1] !== 3'd0) begin
            errors++; $display("FAIL midrst_drain: got vld %b cnt %0d expected 0 0", out_valid[1], cnt[1]);
        end
        idle_all();
    endtask

    task automatic test_random();
        bit    acc [N];
        bit    psh [N];
        bit    pp  [N];
        bit    er, ev, el;
        logic [7:0] ed;
        int    size, lasts;
        rst = 1'b1;
        idle_all();
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < N; k++) begin
            mq[k].delete();
            acc[k] = 1'b0;
        end
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            for (int k = 0; k < N; k++) begin
                if (acc[k]) in_valid[k] = 1'b0;
                if (!in_valid[k] && $urandom_range(3) != 0) begin
                    in_valid[k] = 1'b1;
                    in_data[k]  = 8'($urandom);
                    in_last[k]  = ($urandom_range(3) == 0);
                end
                out_ready[k] = ($urandom_range(3) != 0);
            end
            #1;
            for (int k = 0; k < N; k++) begin
                size  = mq[k].size();
                lasts = 0;
                foreach (mq[k][j]) if (mq[k][j][8]) lasts++;
                if (DEP[k] == 0) begin
                    er = out_ready[k]; ev = in_valid[k]; ed = in_data[k]; el = in_last[k];
                end else begin
                    er = (size != DEP[k]);
                    ev = (size != 0) && (PKT[k] == 0 || lasts != 0 || size == DEP[k]);
                    {el, ed} = (size != 0) ? mq[k][0] : 9'h0;
                end
                checks++;
                if (in_ready[k] !== er || out_valid[k] !== ev) begin
                    errors++; $display("FAIL rnd_handshake[%0d] cyc %0d: got rdy %b vld %b expected %b %b",
                                       k, cyc, in_ready[k], out_valid[k], er, ev);
                end
                if (ev) begin
                    checks++;
                    if (out_data[k] !== ed || out_last[k] !== el) begin
                        errors++; $display("FAIL rnd_beat[%0d] cyc %0d: got %h/%b expected %h/%b",
                                           k, cyc, out_data[k], out_last[k], ed, el);
                    end
                end
                checks++;
                if (cnt[k] !== 3'(size) || pcnt[k] !== 3'(lasts)) begin
                    errors++; $display("FAIL rnd_count[%0d] cyc %0d: got %0d/%0d expected %0d/%0d",
                                       k, cyc, cnt[k], pcnt[k], size, lasts);
                end
                psh[k] = in_valid[k] && er;
                pp[k]  = ev && out_ready[k];
                acc[k] = psh[k];
            end
            @(posedge clk);
            for (int k = 0; k < N; k++) begin
                if (DEP[k] != 0) begin
                    if (pp[k]) void'(mq[k].pop_front());
                    if (psh[k]) mq[k].push_back({in_last[k], in_data[k]});
                end
            end
        end
        idle_all();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        idle_all();
        test_reset();
        test_stream();
        test_full();
        test_packet();
        test_long_burst();
        test_half_rate();
        test_mid_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
